fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the next-PC unit.
- Owns the architectural PC register, issues single-outstanding word reads to instruction memory, and buffers the returned instruction for the decode stage over a valid/ready handshake.
- Drives the PC and stall inputs of the next-PC unit. Accepts the next-PC unit's nPC as a redirect target when a branch, jump or register jump resolves.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- redirect  in  1  take redirect_pc as next fetch address; flushes in-flight/held instruction
- redirect_pc  in  32  redirect target (nPC from next-PC unit)
- imem_req  out  1  instruction-memory read request
- imem_addr  out  32  word address of request (= pc_out)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid (>=1 cycle after gnt)
- imem_rdata  in  32  instruction word
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts instruction
- id_instr  out  32  buffered instruction
- id_pc  out  32  PC of id_instr
- id_pc4  out  32  id_pc + 4, modulo 2^32
- id_misalign  out  1  id_pc[1:0] != 0; id_instr is 32'h0 (NOP)
- pc_out  out  32  PC currently fetched/held; feeds next-PC unit PC
- stall_npc  out  1  feeds next-PC unit stall

Behaviour:
- Reset: state=IDLE; pc_out=RESET_PC; imem_req=0; id_valid=0; id_instr=0; id_misalign=0; drop=0; stall_npc=1.
- Reset mid-operation: any outstanding response is dropped. imem_rvalid in the cycle after reset is ignored if drop was set; drop is set on reset only when state was WAIT.
- States:
  - IDLE: next cycle -> REQ.
  - REQ: imem_req=1, imem_addr=pc_out. On gnt -> WAIT. If pc_out misaligned, no request is issued: go straight to HOLD with id_misalign=1, id_instr=0.
  - WAIT: imem_req=0. On rvalid: capture id_instr<=imem_rdata, id_pc<=pc_out -> HOLD.
  - HOLD: id_valid=1; outputs stable until handshake. On id_valid&id_ready: pc_out<=pc_out+4 (wraps), -> REQ.
- Single outstanding request. No new request while in WAIT. Minimum latency for zero-wait memory is REQ(gnt) -> WAIT(rvalid) -> HOLD(handshake): 3 cycles per instruction.
- stall_npc = ~(id_valid & id_ready) | redirect. It is deasserted exactly in the cycle pc_out advances.
- Redirect (priority over all other events):
  - pc_out<=redirect_pc; id_valid<=0 next cycle; misalign re-evaluated from new pc.
  - IDLE/REQ: -> REQ with new address next cycle. Any gnt in the redirect cycle is treated as for the old address, so drop<=1 and -> WAIT.
  - WAIT, rvalid=0: drop<=1, stay WAIT. The next rvalid is discarded, then drop<=0 -> REQ.
  - WAIT, rvalid=1 same cycle: data discarded -> REQ.
  - HOLD: buffer discarded -> REQ. A same-cycle id_ready handshake is void: pc_out takes redirect_pc, not pc+4. Decode is flushed by the same redirect.
- Back-to-back redirects: the last one wins. drop stays 1 until exactly one stale response is consumed.
- imem_rvalid outside WAIT is ignored.

Test Plan:
- Reset then zero-wait memory (gnt same cycle as req, rvalid 1 cycle later), id_ready=1 -> fetch addresses 0,4,8 at cycles 1,4,7. id_pc4 = id_pc+4. stall_npc low only on cycles 3,6,9.
- Decode backpressure: id_ready=0 for 5 cycles in HOLD with instr 32'h2408_0005 -> id_instr/id_pc held constant, imem_req=0, stall_npc=1. Release -> next req at pc+4.
- Redirect to 32'h0000_0040 during WAIT; stale rvalid returns 32'hDEAD_BEEF 3 cycles later -> data discarded, id_valid stays 0, next imem_addr=32'h40. Its instruction is delivered with id_pc=32'h40.
- Redirect in HOLD coincident with id_ready=1 at pc 32'h10 -> pc_out=redirect_pc, not 32'h14. id_valid=0 next cycle.
- Redirect to 32'h0000_0042 -> no imem_req issued; id_valid=1, id_misalign=1, id_instr=0, id_pc=32'h42.
- Wrap: redirect to 32'hFFFF_FFFC, handshake -> next imem_addr=32'h0, id_pc4 of that instruction = 32'h0. Assert rst in WAIT -> outputs return to reset values next cycle and the stale rvalid is ignored.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, decode and next-PC signals of the fetch stage
interface fetch_stage_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_misalign;
    logic [31:0] pc_out;
    logic        stall_npc;
    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4, id_misalign, pc_out, stall_npc
    );
    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4, id_misalign, pc_out, stall_npc
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues single-outstanding word reads and buffers the instruction for decode
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    state_t      state;
    logic [31:0] pc;
    logic        drop;
    logic        mis;
    logic        req;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_misalign;
    assign mis             = pc[1:0] != 2'b00;
    assign req             = state == REQ && !mis;
    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.pc_out      = pc;
    assign bus.id_valid    = id_valid;
    assign bus.id_instr    = id_instr;
    assign bus.id_pc       = id_pc;
    assign bus.id_pc4      = id_pc + 32'd4;
    assign bus.id_misalign = id_misalign;
    assign bus.stall_npc   = !(id_valid && bus.id_ready) || bus.redirect;
    // Fetch sequencing; redirect beats every other event, drop marks one stale response to swallow
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop        <= state == WAIT;
            id_valid    <= 1'b0;
            id_instr    <= 32'h0;
            id_pc       <= RESET_PC;
            id_misalign <= 1'b0;
        end else begin
            if (bus.imem_rvalid) drop <= 1'b0;
            if (bus.redirect) begin
                pc       <= bus.redirect_pc;
                id_valid <= 1'b0;
                case (state)
                    REQ: begin
                        drop  <= req && bus.imem_gnt ? 1'b1 : drop && !bus.imem_rvalid;
                        state <= req && bus.imem_gnt ? WAIT : REQ;
                    end
                    WAIT: begin
                        if (bus.imem_rvalid) state <= REQ;
                        else drop <= 1'b1;
                    end
                    default: state <= REQ;
                endcase
            end else begin
                case (state)
                    IDLE: state <= REQ;
                    REQ: begin
                        if (mis) begin
                            id_valid    <= 1'b1;
                            id_misalign <= 1'b1;
                            id_instr    <= 32'h0;
                            id_pc       <= pc;
                            state       <= HOLD;
                        end else if (bus.imem_gnt) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.imem_rvalid && drop) begin
                            state <= REQ;
                        end else if (bus.imem_rvalid) begin
                            id_valid    <= 1'b1;
                            id_misalign <= 1'b0;
                            id_instr    <= bus.imem_rdata;
                            id_pc       <= pc;
                            state       <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (bus.id_ready) begin
                            pc       <= pc + 32'd4;
                            id_valid <= 1'b0;
                            state    <= REQ;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench; the model is the architectural instruction stream
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fetch_stage_if bus();
    fetch_stage #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;
    int tests = 0;
    int fails = 0;
    int delivered = 0;
    int cyc = 0;
    ent_t exq[$];
    logic [31:0] ovr [logic [31:0]];
    int lat = 1;
    int gnt_pct = 100;
    bit ovr_once = 0;
    logic [31:0] ovr_data = 32'h0;
    bit pend = 0;
    int cnt = 0;
    logic [31:0] pdata = 32'h0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    function automatic logic [31:0] memf(logic [31:0] a);
        return ovr.exists(a) ? ovr[a] : (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction
    function automatic ent_t ent(logic [31:0] a);
        ent_t e;
        e.pc = a;
        e.mis = a[1:0] != 2'b00;
        e.instr = e.mis ? 32'h0 : memf(a);
        return e;
    endfunction
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic restart(logic [31:0] a);
        exq.delete();
        exq.push_back(ent(a));
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic timeout(string n);
        tests++;
        fails++;
        $display("FAIL %s: timed out", n);
    endtask
    task automatic wait_valid(string n, int max, output bit req_seen);
        bit ok = 0;
        req_seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.imem_req) req_seen = 1;
            if (bus.id_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout(n);
    endtask
    task automatic wait_req(string n, int max);
        bit ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout(n);
    endtask
    task automatic reset_checks(string n);
        chk({n, "_req"}, {31'h0, bus.imem_req}, 32'h0);
        chk({n, "_valid"}, {31'h0, bus.id_valid}, 32'h0);
        chk({n, "_instr"}, bus.id_instr, 32'h0);
        chk({n, "_mis"}, {31'h0, bus.id_misalign}, 32'h0);
        chk({n, "_pc"}, bus.pc_out, 32'h0);
        chk({n, "_stall"}, {31'h0, bus.stall_npc}, 32'h1);
    endtask
    // instruction memory: one outstanding read, configurable grant rate and latency
    initial begin
        bus.imem_gnt = 0;
        bus.imem_rvalid = 0;
        bus.imem_rdata = 0;
        forever begin
            tick();
            bus.imem_rvalid = 0;
            if (pend) begin
                if (cnt == 0) begin
                    bus.imem_rvalid = 1;
                    bus.imem_rdata = pdata;
                    pend = 0;
                end else cnt--;
            end
            if (!bus.imem_rvalid) bus.imem_rdata = $urandom;
            bus.imem_gnt = bus.imem_req && !pend && ($urandom_range(99) < gnt_pct);
            if (bus.imem_gnt) begin
                pend = 1;
                cnt = lat - 1;
                pdata = ovr_once ? ovr_data : memf(bus.imem_addr);
                ovr_once = 0;
            end
        end
    end
    // monitor: every accepted instruction is the next one of the architectural stream
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.id_valid && bus.id_ready && !bus.redirect) begin
                if (exq.size() == 0) begin
                    timeout("sb_empty");
                end else begin
                    e = exq.pop_front();
                    chk("sb_pc", bus.id_pc, e.pc);
                    chk("sb_instr", bus.id_instr, e.instr);
                    chk("sb_mis", {31'h0, bus.id_misalign}, {31'h0, e.mis});
                    chk("sb_pc4", bus.id_pc4, e.pc + 32'd4);
                    chk("sb_pc_out", bus.pc_out, e.pc);
                    exq.push_back(ent(e.pc + 32'd4));
                    delivered++;
                end
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [9:0] reqm;
        logic [9:0] stm;
        logic [31:0] addrs[$];
        bit rs;
        int r;
        bus.redirect = 0;
        bus.redirect_pc = 0;
        bus.id_ready = 1;
        ovr[32'hC] = 32'h2408_0005;
        reqm = 0;
        stm = 0;
        repeat (2) tick();
        rst = 0;
        restart(32'h0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) reset_checks("reset");
            if (bus.imem_req) begin
                reqm[c] = 1'b1;
                addrs.push_back(bus.imem_addr);
            end
            if (!bus.stall_npc) stm[c] = 1'b1;
        end
        chk("req_cycles", {22'h0, reqm}, 32'h092);
        chk("stall_low_cycles", {22'h0, stm}, 32'h248);
        chk("req_count", addrs.size(), 3);
        for (int i = 0; i < addrs.size() && i < 3; i++) chk("req_addr", addrs[i], 32'(4 * i));
        tick();
        bus.id_ready = 0;
        wait_valid("bp_wait", 20, rs);
        for (int i = 0; i < 5; i++) begin
            chk("bp_instr", bus.id_instr, 32'h2408_0005);
            chk("bp_pc", bus.id_pc, 32'hC);
            chk("bp_req", {31'h0, bus.imem_req}, 32'h0);
            chk("bp_stall", {31'h0, bus.stall_npc}, 32'h1);
            if (i < 4) @(negedge clk);
        end
        tick();
        bus.id_ready = 1;
        lat = 3;
        ovr_once = 1;
        ovr_data = 32'hDEAD_BEEF;
        wait_req("bp_release", 20);
        chk("bp_next_addr", bus.imem_addr, 32'h10);
        tick();
        bus.redirect = 1;
        bus.redirect_pc = 32'h40;
        restart(32'h40);
        lat = 1;
        tick();
        bus.redirect = 0;
        begin
            bit ok = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("stale_valid", {31'h0, bus.id_valid}, 32'h0);
                if (bus.imem_req) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) timeout("stale_req");
        end
        chk("stale_next_addr", bus.imem_addr, 32'h40);
        wait_valid("stale_deliver", 20, rs);
        chk("redir_pc", bus.id_pc, 32'h40);
        chk("redir_instr", bus.id_instr, memf(32'h40));
        tick();
        bus.id_ready = 0;
        bus.redirect = 1;
        bus.redirect_pc = 32'h10;
        restart(32'h10);
        tick();
        bus.redirect = 0;
        wait_valid("hold_wait", 20, rs);
        chk("hold_pc", bus.id_pc, 32'h10);
        tick();
        bus.id_ready = 1;
        bus.redirect = 1;
        bus.redirect_pc = 32'h80;
        restart(32'h80);
        @(negedge clk);
        chk("hold_redir_stall", {31'h0, bus.stall_npc}, 32'h1);
        tick();
        bus.redirect = 0;
        @(negedge clk);
        chk("hold_redir_pc", bus.pc_out, 32'h80);
        chk("hold_redir_valid", {31'h0, bus.id_valid}, 32'h0);
        tick();
        bus.id_ready = 0;
        bus.redirect = 1;
        bus.redirect_pc = 32'h42;
        restart(32'h42);
        tick();
        bus.redirect = 0;
        wait_valid("mis_wait", 20, rs);
        chk("mis_noreq", {31'h0, rs}, 32'h0);
        chk("mis_flag", {31'h0, bus.id_misalign}, 32'h1);
        chk("mis_instr", bus.id_instr, 32'h0);
        chk("mis_pc", bus.id_pc, 32'h42);
        tick();
        bus.redirect = 1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        restart(32'hFFFF_FFFC);
        tick();
        bus.redirect = 0;
        wait_valid("wrap_wait", 20, rs);
        chk("wrap_pc", bus.id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", bus.id_pc4, 32'h0);
        tick();
        bus.id_ready = 1;
        lat = 3;
        ovr_once = 1;
        ovr_data = 32'hDEAD_BEEF;
        wait_req("wrap_req", 20);
        chk("wrap_next_addr", bus.imem_addr, 32'h0);
        tick();
        rst = 1;
        lat = 1;
        restart(32'h0);
        tick();
        rst = 0;
        @(negedge clk);
        reset_checks("midreset");
        wait_valid("midreset_deliver", 20, rs);
        chk("midreset_pc", bus.id_pc, 32'h0);
        chk("midreset_instr", bus.id_instr, memf(32'h0));
        gnt_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            tick();
            bus.redirect = 0;
            rst = 0;
            lat = $urandom_range(4, 1);
            bus.id_ready = $urandom_range(99) < 70;
            r = $urandom_range(999);
            if (r < 5) begin
                rst = 1;
                restart(32'h0);
            end else if (r < 40) begin
                bus.redirect = 1;
                bus.redirect_pc = $urandom_range(9) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
                restart(bus.redirect_pc);
            end
        end
        tick();
        bus.redirect = 0;
        rst = 0;
        chk("liveness", {31'h0, delivered > 100}, 32'h1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
